// File: rtl/strobe_encoder.sv
// Strobe encoder: turns single-cycle request strobes into RISE/FALL pulses or
// TOGGLE level flips, queueing overlapping requests in a saturating pending counter.
module strobe_encoder #(
  parameter string TYPE        = "RISE",
  parameter int    HIGH_CYCLES = 2,
  parameter int    LOW_CYCLES  = 2,
  parameter int    PEND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb_in,
  input  logic                  ovf_clr,
  output logic                  stb_out,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0]         HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]         LOW_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic [TW-1:0]         TIMER_ONE = TW'(1);
  localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = {PEND_WIDTH{1'b1}};

  localparam logic IS_FALL    = (TYPE == "FALL");
  localparam logic IS_TOGGLE  = (TYPE == "TOGGLE");
  localparam logic INACT_LVL  = IS_FALL;
  localparam logic ACT_LVL    = ~IS_FALL;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [TW-1:0]           timer_r, timer_nxt_s;
  logic [PEND_WIDTH-1:0]   pending_r, pending_nxt_s;
  logic                    overflow_r, overflow_nxt_s;
  logic                    stb_out_r, stb_nxt_s;

  logic                    timer_zero_s;
  logic                    req_s;
  logic                    start_s;
  logic                    direct_s;
  logic                    inc_s;
  logic                    dec_s;
  logic                    ovf_evt_s;
  logic                    start_lvl_s;

  assign timer_zero_s = (timer_r == {TW{1'b0}});
  assign req_s        = stb_in || (pending_r != {PEND_WIDTH{1'b0}});
  assign start_s      = req_s && ((state_r == IDLE) || ((state_r == GAP) && timer_zero_s));
  // With nothing queued, a same-cycle strobe is served directly and bypasses the counter.
  assign direct_s     = start_s && (pending_r == {PEND_WIDTH{1'b0}});
  assign inc_s        = stb_in && !direct_s;
  assign dec_s        = start_s && !direct_s;
  assign start_lvl_s  = IS_TOGGLE ? ~stb_out_r : ACT_LVL;

  // Phase sequencing and encoded output level.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    stb_nxt_s   = stb_out_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = ACTIVE;
          timer_nxt_s = HIGH_LOAD;
          stb_nxt_s   = start_lvl_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (timer_zero_s) begin
          state_nxt_s = GAP;
          timer_nxt_s = LOW_LOAD;
          stb_nxt_s   = IS_TOGGLE ? stb_out_r : INACT_LVL;
        end else begin
          timer_nxt_s = timer_r - TIMER_ONE;
        end
      end
      GAP: begin
        if (timer_zero_s) begin
          if (start_s) begin
            state_nxt_s = ACTIVE;
            timer_nxt_s = HIGH_LOAD;
            stb_nxt_s   = start_lvl_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          timer_nxt_s = timer_r - TIMER_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        timer_nxt_s = {TW{1'b0}};
      end
    endcase
  end

  // Pending counter bookkeeping and sticky overflow.
  always_comb begin
    pending_nxt_s = pending_r;
    ovf_evt_s     = 1'b0;
    case ({inc_s, dec_s})
      2'b10: begin
        if (pending_r == PEND_MAX) begin
          ovf_evt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r + PEND_ONE;
        end
      end
      2'b01:   pending_nxt_s = pending_r - PEND_ONE;
      default: pending_nxt_s = pending_r;
    endcase
    if (ovf_evt_s) begin
      overflow_nxt_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      timer_r    <= {TW{1'b0}};
      pending_r  <= {PEND_WIDTH{1'b0}};
      overflow_r <= 1'b0;
      stb_out_r  <= INACT_LVL;
    end else begin
      state_r    <= state_nxt_s;
      timer_r    <= timer_nxt_s;
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
      stb_out_r  <= stb_nxt_s;
    end
  end

  assign stb_out  = stb_out_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;
  assign busy     = (state_r != IDLE) || (pending_r != {PEND_WIDTH{1'b0}});

endmodule

// File: tb/tb_strobe_encoder.sv
// Self-checking bench for strobe_encoder: four parameterisations, scoreboard queue of
// expected event edges plus per-edge checks of output level, busy, pending and overflow.
module tb_strobe_encoder;

  logic clk, rst, ovf_clr;
  logic rise_stb, fall_stb, tog_stb, sat_stb;
  logic rise_out, rise_busy, rise_ovf;
  logic fall_out, fall_busy, fall_ovf;
  logic tog_out, tog_busy, tog_ovf;
  logic sat_out, sat_busy, sat_ovf;
  logic [3:0] rise_pend, fall_pend, tog_pend;
  logic [1:0] sat_pend;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  strobe_encoder u_rise (.clk(clk), .rst(rst), .stb_in(rise_stb), .ovf_clr(ovf_clr),
    .stb_out(rise_out), .busy(rise_busy), .pending(rise_pend), .overflow(rise_ovf));

  strobe_encoder #(.TYPE("FALL"), .HIGH_CYCLES(3), .LOW_CYCLES(1)) u_fall (.clk(clk), .rst(rst),
    .stb_in(fall_stb), .ovf_clr(ovf_clr), .stb_out(fall_out), .busy(fall_busy),
    .pending(fall_pend), .overflow(fall_ovf));

  strobe_encoder #(.TYPE("TOGGLE")) u_tog (.clk(clk), .rst(rst), .stb_in(tog_stb),
    .ovf_clr(ovf_clr), .stb_out(tog_out), .busy(tog_busy), .pending(tog_pend), .overflow(tog_ovf));

  strobe_encoder #(.HIGH_CYCLES(3), .LOW_CYCLES(3), .PEND_WIDTH(2)) u_sat (.clk(clk), .rst(rst),
    .stb_in(sat_stb), .ovf_clr(ovf_clr), .stb_out(sat_out), .busy(sat_busy),
    .pending(sat_pend), .overflow(sat_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ovf_clr = 1'b0;
    rise_stb = 1'b0; fall_stb = 1'b0; tog_stb = 1'b0; sat_stb = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ovf_clr = 1'b0;
    rise_stb = 1'b0; fall_stb = 1'b0; tog_stb = 1'b0; sat_stb = 1'b0;
    #2;
    checks++; if (rise_out !== 1'b0) begin errors++; $display("FAIL reset_rise_out: got %b expected 0", rise_out); end
    checks++; if (fall_out !== 1'b1) begin errors++; $display("FAIL reset_fall_out: got %b expected 1", fall_out); end
    checks++; if (tog_out !== 1'b0) begin errors++; $display("FAIL reset_tog_out: got %b expected 0", tog_out); end
    checks++; if ({rise_busy, fall_busy, tog_busy, sat_busy} !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b expected 0000", {rise_busy, fall_busy, tog_busy, sat_busy}); end
    checks++; if ({rise_pend, sat_pend} !== 6'd0) begin errors++; $display("FAIL reset_pending: got %0d/%0d expected 0/0", rise_pend, sat_pend); end
    checks++; if ({rise_ovf, fall_ovf, tog_ovf, sat_ovf} !== 4'b0000) begin errors++; $display("FAIL reset_overflow: got %b expected 0000", {rise_ovf, fall_ovf, tog_ovf, sat_ovf}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic prev, exp_o, exp_b;
    int got;
    do_reset();
    prev = rise_out;
    for (int e = 1; e <= 16; e++) begin
      rise_stb = (e == 10);
      if (e == 10) exp_q.push_back(e);
      tick();
      rise_stb = 1'b0;
      exp_o = (e == 10 || e == 11);
      exp_b = (e >= 10 && e <= 13);
      checks++; if (rise_out !== exp_o) begin errors++; $display("FAIL single_out e=%0d: got %b expected %b", e, rise_out, exp_o); end
      checks++; if (rise_busy !== exp_b) begin errors++; $display("FAIL single_busy e=%0d: got %b expected %b", e, rise_busy, exp_b); end
      checks++; if (rise_pend !== 4'd0) begin errors++; $display("FAIL single_pend e=%0d: got %0d expected 0", e, rise_pend); end
      if (rise_out === 1'b1 && prev === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb: unexpected pulse at edge %0d, expected none", e); end
        else begin got = exp_q.pop_front(); if (got != e) begin errors++; $display("FAIL single_sb: pulse at edge %0d expected %0d", e, got); end end
      end
      prev = rise_out;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic prev, exp_o, exp_b;
    logic [3:0] exp_p;
    int got;
    do_reset();
    prev = rise_out;
    for (int e = 1; e <= 24; e++) begin
      rise_stb = (e >= 10 && e <= 12);
      if (e >= 10 && e <= 12) exp_q.push_back(10 + 4 * (e - 10));
      tick();
      rise_stb = 1'b0;
      exp_o = (e == 10 || e == 11 || e == 14 || e == 15 || e == 18 || e == 19);
      exp_b = (e >= 10 && e <= 21);
      exp_p = (e == 11) ? 4'd1 : (e == 12 || e == 13) ? 4'd2 : (e >= 14 && e <= 17) ? 4'd1 : 4'd0;
      checks++; if (rise_out !== exp_o) begin errors++; $display("FAIL b2b_out e=%0d: got %b expected %b", e, rise_out, exp_o); end
      checks++; if (rise_busy !== exp_b) begin errors++; $display("FAIL b2b_busy e=%0d: got %b expected %b", e, rise_busy, exp_b); end
      checks++; if (rise_pend !== exp_p) begin errors++; $display("FAIL b2b_pend e=%0d: got %0d expected %0d", e, rise_pend, exp_p); end
      if (rise_out === 1'b1 && prev === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb: unexpected pulse at edge %0d, expected none", e); end
        else begin got = exp_q.pop_front(); if (got != e) begin errors++; $display("FAIL b2b_sb: pulse at edge %0d expected %0d", e, got); end end
      end
      prev = rise_out;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_fall();
    logic prev, exp_o;
    int got;
    do_reset();
    checks++; if (fall_out !== 1'b1) begin errors++; $display("FAIL fall_idle: got %b expected 1", fall_out); end
    prev = fall_out;
    for (int e = 1; e <= 14; e++) begin
      fall_stb = (e == 5 || e == 7);
      if (e == 5) exp_q.push_back(5);
      if (e == 7) exp_q.push_back(9);
      tick();
      fall_stb = 1'b0;
      exp_o = !((e >= 5 && e <= 7) || (e >= 9 && e <= 11));
      checks++; if (fall_out !== exp_o) begin errors++; $display("FAIL fall_out e=%0d: got %b expected %b", e, fall_out, exp_o); end
      if (fall_out === 1'b0 && prev === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fall_sb: unexpected pulse at edge %0d, expected none", e); end
        else begin got = exp_q.pop_front(); if (got != e) begin errors++; $display("FAIL fall_sb: pulse at edge %0d expected %0d", e, got); end end
      end
      prev = fall_out;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fall_missing: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_toggle();
    logic prev, exp_o;
    int got, flips;
    do_reset();
    prev = tog_out;
    flips = 0;
    for (int e = 1; e <= 40; e++) begin
      tog_stb = (e >= 20 && e <= 23);
      if (e >= 20 && e <= 23) exp_q.push_back(20 + 4 * (e - 20));
      tick();
      tog_stb = 1'b0;
      if (e == 20 || e == 24 || e == 28 || e == 32) flips++;
      exp_o = flips[0];
      checks++; if (tog_out !== exp_o) begin errors++; $display("FAIL tog_out e=%0d: got %b expected %b", e, tog_out, exp_o); end
      if (tog_out !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL tog_sb: unexpected flip at edge %0d, expected none", e); end
        else begin got = exp_q.pop_front(); if (got != e) begin errors++; $display("FAIL tog_sb: flip at edge %0d expected %0d", e, got); end end
      end
      prev = tog_out;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tog_missing: got %0d left, expected 0", exp_q.size()); end
    checks++; if (tog_busy !== 1'b0) begin errors++; $display("FAIL tog_busy_end: got %b expected 0", tog_busy); end
  endtask

  task automatic test_saturate();
    logic prev, exp_o, exp_v;
    logic [1:0] exp_p;
    int got, phases;
    do_reset();
    prev = sat_out;
    phases = 0;
    for (int e = 1; e <= 34; e++) begin
      sat_stb = (e <= 6);
      ovf_clr = (e == 30);
      if (e <= 4) exp_q.push_back(1 + 6 * (e - 1));
      tick();
      sat_stb = 1'b0;
      ovf_clr = 1'b0;
      exp_o = (e >= 1 && e <= 3) || (e >= 7 && e <= 9) || (e >= 13 && e <= 15) || (e >= 19 && e <= 21);
      exp_p = (e == 1) ? 2'd0 : (e == 2) ? 2'd1 : (e == 3) ? 2'd2 : (e <= 6) ? 2'd3 :
              (e <= 12) ? 2'd2 : (e <= 18) ? 2'd1 : 2'd0;
      exp_v = (e >= 5 && e < 30);
      checks++; if (sat_out !== exp_o) begin errors++; $display("FAIL sat_out e=%0d: got %b expected %b", e, sat_out, exp_o); end
      checks++; if (sat_pend !== exp_p) begin errors++; $display("FAIL sat_pend e=%0d: got %0d expected %0d", e, sat_pend, exp_p); end
      checks++; if (sat_ovf !== exp_v) begin errors++; $display("FAIL sat_ovf e=%0d: got %b expected %b", e, sat_ovf, exp_v); end
      if (sat_out === 1'b1 && prev === 1'b0) begin
        phases++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sat_sb: unexpected pulse at edge %0d, expected none", e); end
        else begin got = exp_q.pop_front(); if (got != e) begin errors++; $display("FAIL sat_sb: pulse at edge %0d expected %0d", e, got); end end
      end
      prev = sat_out;
    end
    checks++; if (phases != 4) begin errors++; $display("FAIL sat_phases: got %0d expected 4", phases); end
    checks++; if (sat_busy !== 1'b0) begin errors++; $display("FAIL sat_busy_end: got %b expected 0", sat_busy); end
  endtask

  task automatic test_reset_mid();
    logic exp_o, exp_b;
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      sat_stb = 1'b1;
      tick();
    end
    sat_stb = 1'b0;
    checks++; if (sat_pend !== 2'd2 || sat_out !== 1'b1) begin errors++; $display("FAIL mid_pre: got pend=%0d out=%b expected pend=2 out=1", sat_pend, sat_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sat_out !== 1'b0) begin errors++; $display("FAIL mid_rst_out: got %b expected 0", sat_out); end
    checks++; if (sat_pend !== 2'd0) begin errors++; $display("FAIL mid_rst_pend: got %0d expected 0", sat_pend); end
    checks++; if (sat_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", sat_busy); end
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      sat_stb = (e == 2);
      tick();
      sat_stb = 1'b0;
      exp_o = (e >= 2 && e <= 4);
      exp_b = (e >= 2 && e <= 7);
      checks++; if (sat_out !== exp_o) begin errors++; $display("FAIL mid_post_out e=%0d: got %b expected %b", e, sat_out, exp_o); end
      checks++; if (sat_busy !== exp_b) begin errors++; $display("FAIL mid_post_busy e=%0d: got %b expected %b", e, sat_busy, exp_b); end
      checks++; if (sat_pend !== 2'd0) begin errors++; $display("FAIL mid_post_pend e=%0d: got %0d expected 0", e, sat_pend); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fall();
    test_toggle();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strobe_encoder.md
STROBE_ENCODER -- requirements
Module: strobe_encoder

Interface
REQ-001 Parameter TYPE, default "RISE", output waveform: "RISE" (idle-low pulse), "FALL" (idle-high pulse), "TOGGLE" (level flip per strobe).
REQ-002 Parameter HIGH_CYCLES, default 2, active-phase length in clk cycles, legal range >=1.
REQ-003 Parameter LOW_CYCLES, default 2, recovery-phase length in clk cycles, legal range >=1.
REQ-004 Parameter PEND_WIDTH, default 4, pending-counter width; counter saturates at 2^PEND_WIDTH-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 stb_in  input  1  single-cycle request strobe; each cycle sampled high is one request.
REQ-008 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-009 stb_out  output  1  registered encoded waveform; one detectable edge event per request.
REQ-010 busy  output  1  high when state is not IDLE or pending count is non-zero.
REQ-011 pending  output  PEND_WIDTH  requests accepted but not yet started.
REQ-012 overflow  output  1  sticky flag; a request was dropped.

Function
REQ-013 FSM states: IDLE, ACTIVE, GAP; one down-counter times both phases, sized for max(HIGH_CYCLES, LOW_CYCLES).
REQ-014 Inactive level is 0 for RISE and 1 for FALL; TOGGLE has no fixed inactive level.
REQ-015 IDLE with stb_in=1 or pending>0 at edge k -> ACTIVE after edge k, with stb_out at the active level (RISE 1, FALL 0, TOGGLE inverted) after edge k.
REQ-016 ACTIVE lasts exactly HIGH_CYCLES cycles, then GAP; RISE/FALL drive the inactive level for the whole GAP; TOGGLE holds its level.
REQ-017 GAP lasts exactly LOW_CYCLES cycles; on its final cycle, stb_in=1 or pending>0 -> ACTIVE directly, otherwise -> IDLE.
REQ-018 Back-to-back request period is exactly HIGH_CYCLES+LOW_CYCLES cycles with no idle cycle inserted.
REQ-019 Latency from stb_in sampled in IDLE with pending=0 to stb_out change is one edge (same edge that samples stb_in).
REQ-020 A request starting ACTIVE in the same cycle it arrives does not touch pending.
REQ-021 Any other stb_in increments pending; each ACTIVE start not served by a same-cycle stb_in decrements pending; a simultaneous increment and decrement leaves pending unchanged.
REQ-022 stb_in with pending at maximum and no same-cycle decrement: request dropped, pending unchanged, overflow set after that edge.
REQ-023 overflow stays set until ovf_clr=1 at an edge; simultaneous ovf_clr and a new overflow event leaves overflow set.
REQ-024 Requests are served in arrival order; every request not dropped yields exactly one ACTIVE phase.
REQ-025 busy is combinational from registered state and pending; it goes low the cycle after GAP exits to IDLE.

Reset
REQ-026 rst=1 forces immediately, independent of clk: state IDLE, timer 0, pending 0, overflow 0, stb_out 0 for RISE/TOGGLE and 1 for FALL.
REQ-027 Reset mid-ACTIVE or mid-GAP discards the current phase and all pending requests; the first request after rst deasserts behaves per REQ-015.

Verification
REQ-028 RISE, defaults, one stb_in at edge 10 -> stb_out=1 after edges 10-11, 0 from edge 12; busy low after edge 14; pending stays 0.
REQ-029 RISE, defaults, stb_in at edges 10, 11, 12 -> pending 1, 2 after edges 11, 12; stb_out pulses start at edges 10, 14, 18; pending 1 after edge 14, 0 after edge 18.
REQ-030 FALL, HIGH_CYCLES=3, LOW_CYCLES=1, stb_in at edges 5 and 7 -> stb_out=0 after edges 5-7, 1 after edge 8, 0 after edges 9-11, then 1; reset value 1.
REQ-031 TOGGLE, defaults, four strobes 1 cycle apart from edge 20 -> stb_out flips after edges 20, 24, 28, 32; final level equals the reset level.
REQ-032 PEND_WIDTH=2, stb_in held high for 6 cycles from idle -> 1 started, pending saturates at 3, 2 requests dropped, overflow=1; ovf_clr -> 0; exactly 4 ACTIVE phases.
REQ-033 rst asserted mid-ACTIVE with pending=2 -> stb_out inactive with no clock, pending 0, busy 0; a new stb_in after release -> single pulse per REQ-028.
